// File: rtl/usi_spi_pkg.sv
// usi_spi_pkg: shared states, SPI mode encodings and counter-width helper
package usi_spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
  function automatic int bcnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/usi_spi_master_drv_if.sv
// usi_spi_master_drv_if: config, word handshake and SPI pin bundle
interface usi_spi_master_drv_if #(
  parameter int DATA_W  = 8,
  parameter int NSS_NUM = 1,
  parameter int DIV_W   = 8,
  parameter int SEL_W   = (NSS_NUM > 1) ? $clog2(NSS_NUM) : 1
) ();
  logic               cfg_cpol;
  logic               cfg_cpha;
  logic               cfg_lsb_first;
  logic [DIV_W-1:0]   cfg_div;
  logic [SEL_W-1:0]   cfg_nss_sel;
  logic               tx_valid;
  logic               tx_ready;
  logic [DATA_W-1:0]  tx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  rx_data;
  logic               busy;
  logic               sck;
  logic               mosi;
  logic               miso;
  logic [NSS_NUM-1:0] nss_n;
  modport master (
    input  cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_div, cfg_nss_sel, tx_valid, tx_data, miso,
    output tx_ready, rx_valid, rx_data, busy, sck, mosi, nss_n
  );
  modport slave (
    output cfg_cpol, cfg_cpha, cfg_lsb_first, cfg_div, cfg_nss_sel, tx_valid, tx_data, miso,
    input  tx_ready, rx_valid, rx_data, busy, sck, mosi, nss_n
  );
endinterface

// File: rtl/usi_spi_clkgen.sv
// usi_spi_clkgen: half-period counter producing a one-cycle strobe at terminal count
module usi_spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_strobe
);
  logic [DIV_W-1:0] r_cnt;
  assign o_strobe = i_en && (r_cnt == i_div);
  // Count 0..i_div and restart; wrapping at terminal count keeps full-width dividers safe
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= o_strobe ? '0 : r_cnt + DIV_W'(1);
  end
endmodule

// File: rtl/usi_spi_master_drv.sv
// usi_spi_master_drv: parametrised full-duplex SPI master engine
module usi_spi_master_drv
  import usi_spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NSS_NUM = 1,
  parameter int DIV_W   = 8,
  parameter int SEL_W   = (NSS_NUM > 1) ? $clog2(NSS_NUM) : 1
) (
  input logic                  clk,
  input logic                  rst,
  usi_spi_master_drv_if.master io_bus
);
  localparam int BCNT_W = bcnt_w(DATA_W);
  localparam int EDGE_W = bcnt_w(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
  state_t              r_state, w_next;
  logic                r_cpha, r_lsb, r_sck, r_mosi, r_rx_valid;
  logic [DIV_W-1:0]    r_div;
  logic [DATA_W-1:0]   r_tx, r_rx, r_rx_data, w_ord, w_rev_tx, w_rev_rx;
  logic [BCNT_W-1:0]   r_bits, w_bits_nx;
  logic [EDGE_W-1:0]   r_edge;
  logic [NSS_NUM-1:0]  r_nss_n, w_nss_sel;
  logic [SEL_W-1:0]    w_sel;
  logic                w_accept, w_strobe, w_lead, w_sample, w_advance, w_last, w_done;

  assign io_bus.tx_ready = (r_state == IDLE) && !rst;
  assign io_bus.busy     = (r_state != IDLE);
  assign io_bus.sck      = r_sck;
  assign io_bus.mosi     = r_mosi;
  assign io_bus.nss_n    = r_nss_n;
  assign io_bus.rx_valid = r_rx_valid;
  assign io_bus.rx_data  = r_rx_data;

  assign w_accept  = io_bus.tx_valid && io_bus.tx_ready;
  assign w_sel     = io_bus.cfg_nss_sel;
  assign w_rev_tx  = {<<{io_bus.tx_data}};
  assign w_rev_rx  = {<<{r_rx}};
  assign w_ord     = io_bus.cfg_lsb_first ? w_rev_tx : io_bus.tx_data;
  assign w_lead    = !r_edge[0];
  assign w_last    = (r_edge == LAST_EDGE);
  assign w_sample  = r_cpha ^ w_lead;
  assign w_advance = r_cpha ? w_lead : (!w_lead && !w_last);
  assign w_bits_nx = r_bits + BCNT_W'(w_sample);
  assign w_done    = w_strobe && w_last && (w_bits_nx == BCNT_W'(DATA_W));

  usi_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state != w_next),
    .i_en     (r_state != IDLE),
    .i_div    (r_div),
    .o_strobe (w_strobe)
  );

  // Decode the requested chip select; out-of-range indices leave every line high
  always_comb begin
    w_nss_sel = '1;
    for (int i = 0; i < NSS_NUM; i++) w_nss_sel[i] = (int'(w_sel) != i);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  // Next-state logic: every non-idle state ends on a half-period strobe
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = SETUP;
      SETUP:   if (w_strobe) w_next = SHIFT;
      SHIFT:   if (w_done)   w_next = HOLD;
      HOLD:    if (w_strobe) w_next = GAP;
      GAP:     if (w_strobe) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch config at accept, shift on strobes, publish word leaving HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_div      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_bits     <= '0;
      r_edge     <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_nss_n    <= '1;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_state == IDLE) begin
        r_sck <= io_bus.cfg_cpol;
        if (w_accept) begin
          r_cpha  <= io_bus.cfg_cpha;
          r_lsb   <= io_bus.cfg_lsb_first;
          r_div   <= io_bus.cfg_div;
          r_tx    <= io_bus.cfg_cpha ? w_ord : w_ord << 1;
          r_mosi  <= !io_bus.cfg_cpha && w_ord[DATA_W-1];
          r_nss_n <= w_nss_sel;
          r_rx    <= '0;
          r_bits  <= '0;
          r_edge  <= '0;
        end
      end
      if (r_state == SHIFT && w_strobe) begin
        r_sck  <= ~r_sck;
        r_edge <= r_edge + EDGE_W'(1);
        if (w_sample) begin
          r_rx   <= {r_rx[DATA_W-2:0], io_bus.miso};
          r_bits <= w_bits_nx;
        end
        if (w_advance) begin
          r_mosi <= r_tx[DATA_W-1];
          r_tx   <= r_tx << 1;
        end
      end
      if (r_state == HOLD && w_strobe) begin
        r_nss_n    <= '1;
        r_rx_data  <= r_lsb ? w_rev_rx : r_rx;
        r_rx_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_usi_spi_master_drv.sv
// tb_usi_spi_master_drv: directed checks of the SPI master engine
module tb_usi_spi_master_drv;
  import usi_spi_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_a = 1'b0, miso_a = 1'b0, loop_b = 1'b0;
  int errors = 0, checks = 0;

  usi_spi_master_drv_if #(.DATA_W(8), .NSS_NUM(4), .DIV_W(8), .SEL_W(2)) ifa ();
  usi_spi_master_drv_if #(.DATA_W(16), .NSS_NUM(3), .DIV_W(8), .SEL_W(2)) ifb ();

  usi_spi_master_drv #(.DATA_W(8), .NSS_NUM(4), .DIV_W(8), .SEL_W(2)) dut_a (
    .clk(clk), .rst(rst), .io_bus(ifa));
  usi_spi_master_drv #(.DATA_W(16), .NSS_NUM(3), .DIV_W(8), .SEL_W(2)) dut_b (
    .clk(clk), .rst(rst), .io_bus(ifb));

  assign ifa.miso = loop_a ? ifa.mosi : miso_a;
  assign ifb.miso = loop_b ? ifb.mosi : 1'b0;

  always #5 clk = ~clk;

  task automatic xfer_a(input logic [1:0] mode, input logic lsb, input logic [7:0] div,
                        input logic [1:0] sel, input logic [7:0] d,
                        output int low, output logic [3:0] fell, output int rv,
                        output logic [7:0] rxw, output logic [7:0] mo, output int tog,
                        output int pmin, output int pmax, output logic to);
    int cyc, last;
    logic prev;
    low = 0; fell = '0; rv = 0; rxw = '0; mo = '0; tog = 0;
    pmin = 1 << 30; pmax = 0; cyc = 0; last = -1; prev = mode[1];
    @(negedge clk);
    ifa.cfg_cpol = mode[1]; ifa.cfg_cpha = mode[0]; ifa.cfg_lsb_first = lsb;
    ifa.cfg_div = div; ifa.cfg_nss_sel = sel; ifa.tx_data = d; ifa.tx_valid = 1'b1;
    @(negedge clk);
    ifa.tx_valid = 1'b0;
    while (!(rv > 0 && !ifa.busy) && cyc < 10000) begin
      if (ifa.nss_n != 4'hF) low++;
      fell |= ~ifa.nss_n;
      if (ifa.rx_valid) begin rv++; rxw = ifa.rx_data; end
      if (ifa.sck != prev) begin
        tog++;
        if (last >= 0) begin
          if (cyc - last < pmin) pmin = cyc - last;
          if (cyc - last > pmax) pmax = cyc - last;
        end
        last = cyc;
        if (ifa.sck) mo = {mo[6:0], ifa.mosi};
      end
      prev = ifa.sck;
      cyc++;
      @(negedge clk);
    end
    to = (cyc >= 10000);
  endtask

  task automatic test_reset;
    ifa.cfg_cpol = 0; ifa.cfg_cpha = 0; ifa.cfg_lsb_first = 0; ifa.cfg_div = '0;
    ifa.cfg_nss_sel = '0; ifa.tx_valid = 0; ifa.tx_data = '0;
    ifb.cfg_cpol = 0; ifb.cfg_cpha = 0; ifb.cfg_lsb_first = 0; ifb.cfg_div = '0;
    ifb.cfg_nss_sel = '0; ifb.tx_valid = 0; ifb.tx_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ifa.tx_ready !== 1'b0) begin errors++; $display("FAIL rst_tx_ready: got %b expected 0", ifa.tx_ready); end
    checks++; if (ifa.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b expected 0", ifa.rx_valid); end
    checks++; if (ifa.rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h expected 00", ifa.rx_data); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", ifa.busy); end
    checks++; if (ifa.sck !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b expected 0", ifa.sck); end
    checks++; if (ifa.mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b expected 0", ifa.mosi); end
    checks++; if (ifa.nss_n !== 4'hF) begin errors++; $display("FAIL rst_nss_n: got %h expected f", ifa.nss_n); end
    checks++; if (ifb.nss_n !== 3'h7) begin errors++; $display("FAIL rst_nss_n_b: got %h expected 7", ifb.nss_n); end
    rst = 1'b0;
    #1;
    checks++; if (ifa.tx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_tx_ready: got %b expected 1", ifa.tx_ready); end
  endtask

  task automatic test_mode0;
    int low, rv, tog, pmin, pmax;
    logic [3:0] fell;
    logic [7:0] rxw, mo;
    logic to;
    loop_a = 1'b1;
    xfer_a(MODE0, 1'b0, 8'd0, 2'd0, 8'h12, low, fell, rv, rxw, mo, tog, pmin, pmax, to);
    checks++; if (to) begin errors++; $display("FAIL m0_timeout: transfer did not complete"); end
    checks++; if (low !== 18) begin errors++; $display("FAIL m0_nss_low: got %0d expected 18", low); end
    checks++; if (fell !== 4'b0001) begin errors++; $display("FAIL m0_nss_fell: got %b expected 0001", fell); end
    checks++; if (mo !== 8'h12) begin errors++; $display("FAIL m0_mosi_bits: got %h expected 12", mo); end
    checks++; if (rxw !== 8'h12) begin errors++; $display("FAIL m0_rx_data: got %h expected 12", rxw); end
    checks++; if (rv !== 1) begin errors++; $display("FAIL m0_rx_valid_count: got %0d expected 1", rv); end
    checks++; if (tog !== 16) begin errors++; $display("FAIL m0_sck_edges: got %0d expected 16", tog); end
    checks++; if (pmax !== 1) begin errors++; $display("FAIL m0_phase: got %0d expected 1", pmax); end
  endtask

  task automatic test_mode3;
    int low, rv, tog, pmin, pmax;
    logic [3:0] fell;
    logic [7:0] rxw, mo;
    logic to;
    loop_a = 1'b0; miso_a = 1'b1;
    @(negedge clk); ifa.cfg_cpol = 1'b1;
    @(negedge clk);
    checks++; if (ifa.sck !== 1'b1) begin errors++; $display("FAIL m3_sck_idle: got %b expected 1", ifa.sck); end
    xfer_a(MODE3, 1'b1, 8'd3, 2'd0, 8'hA5, low, fell, rv, rxw, mo, tog, pmin, pmax, to);
    checks++; if (to) begin errors++; $display("FAIL m3_timeout: transfer did not complete"); end
    checks++; if (low !== 72) begin errors++; $display("FAIL m3_nss_low: got %0d expected 72", low); end
    checks++; if (mo !== 8'hA5) begin errors++; $display("FAIL m3_mosi_bits: got %h expected a5", mo); end
    checks++; if (rxw !== 8'hFF) begin errors++; $display("FAIL m3_rx_data: got %h expected ff", rxw); end
    checks++; if (pmin !== 4 || pmax !== 4) begin errors++; $display("FAIL m3_phase: got %0d..%0d expected 4..4", pmin, pmax); end
    checks++; if (ifa.sck !== 1'b1) begin errors++; $display("FAIL m3_sck_end: got %b expected 1", ifa.sck); end
    miso_a = 1'b0;
  endtask

  task automatic test_nss_select;
    int low, rv, tog, pmin, pmax;
    logic [3:0] fell;
    logic [7:0] rxw, mo;
    logic to;
    loop_a = 1'b1;
    @(negedge clk); ifa.cfg_cpol = 1'b0;
    xfer_a(MODE0, 1'b0, 8'd0, 2'd2, 8'h34, low, fell, rv, rxw, mo, tog, pmin, pmax, to);
    checks++; if (fell !== 4'b0100) begin errors++; $display("FAIL sel2_nss_fell: got %b expected 0100", fell); end
    checks++; if (rxw !== 8'h34) begin errors++; $display("FAIL sel2_rx_data: got %h expected 34", rxw); end
    checks++; if (low !== 18) begin errors++; $display("FAIL sel2_nss_low: got %0d expected 18", low); end
    xfer_a(MODE0, 1'b0, 8'd0, 2'd3, 8'h56, low, fell, rv, rxw, mo, tog, pmin, pmax, to);
    checks++; if (fell !== 4'b1000) begin errors++; $display("FAIL sel3_nss_fell: got %b expected 1000", fell); end
    checks++; if (rxw !== 8'h56) begin errors++; $display("FAIL sel3_rx_data: got %h expected 56", rxw); end
  endtask

  task automatic test_dummy_sel;
    int cyc, rv;
    logic [2:0] fell;
    logic [15:0] rxw;
    cyc = 0; rv = 0; fell = '0; rxw = '0;
    loop_b = 1'b1;
    @(negedge clk);
    ifb.cfg_nss_sel = 2'd3; ifb.tx_data = 16'hBEEF; ifb.tx_valid = 1'b1;
    @(negedge clk);
    ifb.tx_valid = 1'b0;
    while (!(rv > 0 && !ifb.busy) && cyc < 500) begin
      fell |= ~ifb.nss_n;
      if (ifb.rx_valid) begin rv++; rxw = ifb.rx_data; end
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc >= 500) begin errors++; $display("FAIL dummy_timeout: transfer did not complete"); end
    checks++; if (fell !== 3'b000) begin errors++; $display("FAIL dummy_nss_fell: got %b expected 000", fell); end
    checks++; if (rv !== 1) begin errors++; $display("FAIL dummy_rx_valid_count: got %0d expected 1", rv); end
    checks++; if (rxw !== 16'hBEEF) begin errors++; $display("FAIL dummy_rx_data: got %h expected beef", rxw); end
    ifb.cfg_nss_sel = 2'd0;
  endtask

  task automatic test_back_to_back;
    int cyc, acc, rv, low, hi, rdy_busy;
    logic [15:0] w0, w1;
    cyc = 0; acc = 0; rv = 0; low = 0; hi = 0; rdy_busy = 0; w0 = '0; w1 = '0;
    loop_b = 1'b1;
    @(negedge clk);
    ifb.cfg_nss_sel = 2'd0; ifb.tx_data = 16'h1234; ifb.tx_valid = 1'b1;
    while (!(rv == 2 && !ifb.busy) && cyc < 500) begin
      if (ifb.tx_ready && ifb.tx_valid) acc++;
      if (acc == 1 && !ifb.tx_ready) ifb.tx_data = 16'h5678;
      if (acc == 2 && !ifb.tx_ready) ifb.tx_valid = 1'b0;
      if (ifb.busy && ifb.tx_ready) rdy_busy++;
      if (!ifb.nss_n[0]) low++;
      else if (low > 0 && low < 68) hi++;
      if (ifb.rx_valid) begin
        if (rv == 0) w0 = ifb.rx_data; else w1 = ifb.rx_data;
        rv++;
      end
      cyc++;
      @(negedge clk);
    end
    ifb.tx_valid = 1'b0;
    checks++; if (cyc >= 500) begin errors++; $display("FAIL b2b_timeout: transfers did not complete"); end
    checks++; if (acc !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc); end
    checks++; if (hi !== 2) begin errors++; $display("FAIL b2b_nss_gap: got %0d expected 2", hi); end
    checks++; if (low !== 68) begin errors++; $display("FAIL b2b_nss_low: got %0d expected 68", low); end
    checks++; if (rdy_busy !== 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d expected 0", rdy_busy); end
    checks++; if (w0 !== 16'h1234) begin errors++; $display("FAIL b2b_word0: got %h expected 1234", w0); end
    checks++; if (w1 !== 16'h5678) begin errors++; $display("FAIL b2b_word1: got %h expected 5678", w1); end
  endtask

  task automatic test_reset_mid;
    int low, rv, tog, pmin, pmax, stray;
    logic [3:0] fell;
    logic [7:0] rxw, mo;
    logic to;
    stray = 0;
    loop_a = 1'b1;
    @(negedge clk);
    ifa.cfg_cpol = 0; ifa.cfg_cpha = 0; ifa.cfg_lsb_first = 0; ifa.cfg_div = 8'd0;
    ifa.cfg_nss_sel = 2'd0; ifa.tx_data = 8'h78; ifa.tx_valid = 1'b1;
    @(negedge clk);
    ifa.tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (ifa.mosi !== 1'b1) begin errors++; $display("FAIL mid_mosi_before: got %b expected 1", ifa.mosi); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ifa.nss_n !== 4'hF) begin errors++; $display("FAIL mid_nss_n: got %h expected f", ifa.nss_n); end
    checks++; if (ifa.sck !== 1'b0) begin errors++; $display("FAIL mid_sck: got %b expected 0", ifa.sck); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", ifa.busy); end
    checks++; if (ifa.mosi !== 1'b0) begin errors++; $display("FAIL mid_mosi: got %b expected 0", ifa.mosi); end
    checks++; if (ifa.tx_ready !== 1'b0) begin errors++; $display("FAIL mid_tx_ready_rst: got %b expected 0", ifa.tx_ready); end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifa.rx_valid) stray++;
      @(negedge clk);
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL mid_rx_valid: got %0d expected 0", stray); end
    xfer_a(MODE0, 1'b0, 8'd0, 2'd0, 8'h9C, low, fell, rv, rxw, mo, tog, pmin, pmax, to);
    checks++; if (rxw !== 8'h9C) begin errors++; $display("FAIL mid_next_rx_data: got %h expected 9c", rxw); end
    checks++; if (low !== 18) begin errors++; $display("FAIL mid_next_nss_low: got %0d expected 18", low); end
    checks++; if (rv !== 1) begin errors++; $display("FAIL mid_next_rx_valid: got %0d expected 1", rv); end
  endtask

  task automatic test_max_div;
    int low, rv, tog, pmin, pmax;
    logic [3:0] fell;
    logic [7:0] rxw, mo;
    logic to;
    loop_a = 1'b1;
    xfer_a(MODE1, 1'b0, 8'hFF, 2'd1, 8'h3C, low, fell, rv, rxw, mo, tog, pmin, pmax, to);
    checks++; if (to) begin errors++; $display("FAIL div_timeout: transfer did not complete"); end
    checks++; if (pmin !== 256 || pmax !== 256) begin errors++; $display("FAIL div_phase: got %0d..%0d expected 256..256", pmin, pmax); end
    checks++; if (low !== 4608) begin errors++; $display("FAIL div_nss_low: got %0d expected 4608", low); end
    checks++; if (rxw !== 8'h3C) begin errors++; $display("FAIL div_rx_data: got %h expected 3c", rxw); end
    checks++; if (fell !== 4'b0010) begin errors++; $display("FAIL div_nss_fell: got %b expected 0010", fell); end
    checks++; if (mo !== 8'h3C) begin errors++; $display("FAIL div_mosi_bits: got %h expected 3c", mo); end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode3;
    test_nss_select;
    test_dummy_sel;
    test_back_to_back;
    test_reset_mid;
    test_max_div;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
